// File: rtl/mem_pkg.sv
// mem_pkg: funct3 encodings, FSM state type and default latency for mem_access_unit
package mem_pkg;
  localparam int LATENCY_DEF = 2;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte enables/replication and load lane extract with extension
// Ports: off/funct3/store select size and lane; wdata/rword in; be/wword/rdata/mis out.
// MEM_MISALIGN_TRAP_EN: flag misaligned half/word instead of forcing alignment.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        mis
);
  logic is_b, is_h, is_w, sgn;
  logic [1:0] a;
  logic [7:0] rb;
  logic [15:0] rh;
  always_comb begin
    is_b = store ? funct3 == F3_B : (funct3 == F3_B || funct3 == F3_BU);
    is_h = store ? funct3 == F3_H : (funct3 == F3_H || funct3 == F3_HU);
    is_w = !is_b && !is_h;
    sgn = !funct3[2];
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (is_h && off[0]) || (is_w && off != 2'b00);
    a = off;
`else
    mis = 1'b0;
    a = is_h ? {off[1], 1'b0} : is_w ? 2'b00 : off;
`endif
    be = is_b ? 4'b0001 << a : is_h ? 4'b0011 << a : 4'b1111;
    wword = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    rb = rword[{a, 3'b000} +: 8];
    rh = rword[{a[1], 4'b0000} +: 16];
    rdata = is_b ? {{24{sgn & rb[7]}}, rb} : is_h ? {{16{sgn & rh[15]}}, rh} : rword;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with wait-state data memory, loads/stores and branch resolve
// Ports: i_clk/i_reset, i_valid/o_ready handshake, request fields from EX, i_flush,
// o_valid strobe with o_readData, o_PCSrc, o_misalign.
// MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap (see mem_lane_align).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_memAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic              i_branch,
  input  logic [2:0]        i_funct3,
  input  logic              i_zero,
  input  logic              i_lt,
  input  logic              i_ltu,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_readData,
  output logic              o_PCSrc,
  output logic              o_misalign
);
  localparam int AW = $clog2(DEPTH);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [AW-1:0] q_idx, idx;
  logic [1:0] q_off, off;
  logic [2:0] q_f3, f3;
  logic q_load, idle, accept, is_mem, is_load, taken, mis;
  logic [3:0] be;
  logic [DATA_W-1:0] wword, rdata;
  logic [DATA_W-1:0] mem [DEPTH];
  always_comb begin
    idle = state == IDLE;
    o_ready = idle;
    o_valid = state == RESP && !i_flush;
    accept = i_valid && idle && !i_flush;
    is_mem = i_memRead || i_memWrite;
    is_load = i_memRead && !i_memWrite;
    taken = i_branch && (i_funct3 == F3_BEQ ? i_zero : i_funct3 == F3_BNE ? !i_zero :
            i_funct3 == F3_BLT ? i_lt : i_funct3 == F3_BGE ? !i_lt :
            i_funct3 == F3_BLTU ? i_ltu : i_funct3 == F3_BGEU ? !i_ltu : 1'b0);
    // In IDLE the lane logic serves the incoming request; otherwise the captured one.
    idx = idle ? i_memAddr[AW+1:2] : q_idx;
    off = idle ? i_memAddr[1:0] : q_off;
    f3 = idle ? i_funct3 : q_f3;
    nxt = state;
    if (idle) nxt = accept ? (is_mem && LATENCY > 0 ? WAIT : RESP) : IDLE;
    else if (state == WAIT) nxt = i_flush ? IDLE : cnt == 4'd0 ? RESP : WAIT;
    else nxt = IDLE;
  end
  mem_lane_align u_lane (
    .off(off), .funct3(f3), .store(idle && i_memWrite), .wdata(i_wrData),
    .rword(mem[idx]), .be(be), .wword(wword), .rdata(rdata), .mis(mis)
  );
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      q_idx <= '0;
      q_off <= '0;
      q_f3 <= '0;
      q_load <= 1'b0;
      o_readData <= '0;
      o_PCSrc <= 1'b0;
      o_misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
        q_idx <= i_memAddr[AW+1:2];
        q_off <= i_memAddr[1:0];
        q_f3 <= i_funct3;
        q_load <= is_load;
        o_PCSrc <= taken;
        o_misalign <= is_mem && mis;
        if (i_memWrite && !mis)
          for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
      // Load data sampled on the edge entering RESP so it sees every earlier store.
      if (nxt == RESP) o_readData <= ((idle ? is_load : q_load) && !mis) ? rdata : '0;
    end
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, 32, data/word width in bits; only 32 supported.
REQ-002 Parameter DEPTH, 256, data memory depth in words; power of two, >=4.
REQ-003 Parameter LATENCY, 2, wait cycles inserted per memory access; 0..15.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-high.
REQ-006 i_valid  input  1  request valid from EX.
REQ-007 o_ready  output  1  unit can accept a request this cycle.
REQ-008 i_memAddr  input  32  byte address (ALU result).
REQ-009 i_wrData  input  32  store data, lane 0 aligned.
REQ-010 i_memRead, i_memWrite, i_branch  input  1 each  operation class.
REQ-011 i_funct3  input  3  access size/sign or branch condition.
REQ-012 i_zero, i_lt, i_ltu  input  1 each  ALU flags (equal, signed less, unsigned less).
REQ-013 i_flush  input  1  abort in-flight access.
REQ-014 o_valid  output  1  one-cycle result strobe.
REQ-015 o_readData  output  32  extended load data; 0 for non-loads.
REQ-016 o_PCSrc  output  1  branch taken, qualified by o_valid.
REQ-017 o_misalign  output  1  misaligned access flag, qualified by o_valid.

Function
REQ-018 Request accepted on a rising edge with i_valid=1 and o_ready=1; o_ready=1 only in IDLE.
REQ-019 FSM states IDLE, WAIT, RESP; non-memory request: IDLE->RESP; memory request: IDLE->WAIT (LATENCY>0) or IDLE->RESP (LATENCY=0).
REQ-020 WAIT counter loads LATENCY-1, decrements each cycle, transitions to RESP at 0.
REQ-021 RESP lasts one cycle, asserts o_valid, returns to IDLE; acceptance-to-o_valid = LATENCY+1 cycles for memory ops, 1 cycle otherwise.
REQ-022 i_valid while o_ready=0 ignored; upstream holds request.
REQ-023 Word index = i_memAddr[log2(DEPTH)+1:2]; higher address bits ignored (wrap-around).
REQ-024 Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; lane from addr[1:0]; sign/zero extended to 32; other codes behave as LW.
REQ-025 Store funct3: 000 SB, 001 SH, 010 SW; only enabled bytes written; other codes behave as SW.
REQ-026 Store committed on acceptance edge; load data sampled on WAIT->RESP (or IDLE->RESP) edge, so load sees all earlier stores.
REQ-027 Branch taken when i_branch=1 and funct3 condition holds: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 never taken; request fields captured at acceptance.
REQ-028 i_memRead and i_memWrite both 1: treated as store, o_readData=0.
REQ-029 i_flush=1 in WAIT or RESP: next state IDLE, o_valid suppressed; committed store not undone; i_flush in IDLE ignored and blocks acceptance that cycle.

Reset
REQ-030 On i_reset assertion, immediately: state IDLE, counter 0, o_valid=0, o_readData=0, o_PCSrc=0, o_misalign=0; o_ready=1 after release.
REQ-031 Memory array cleared to zero on reset; reset mid-access abandons it with no o_valid.

Configuration
REQ-032 Macro MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 sets o_misalign=1 at RESP, store suppressed, o_readData=0.
REQ-033 Macro undefined: o_misalign tied 0; misaligned halfword/word forced aligned by clearing offending address bits.

Structure
REQ-034 Package mem_pkg holds funct3 load/store/branch encodings, FSM state enum, LATENCY default.
REQ-035 Sub-module mem_lane_align: store byte-enable/replication and load lane extract/extension.

Verification
REQ-036 LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 -> o_valid 3 cycles after each acceptance, o_readData=0xDEADBEEF.
REQ-037 SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-038 Branch BLT i_lt=1 -> o_valid next cycle with o_PCSrc=1; BGEU i_ltu=1 -> o_PCSrc=0; branch with i_branch=0 -> o_PCSrc=0.
REQ-039 Load accepted, i_flush one cycle later -> no o_valid, o_ready=1 next cycle; i_reset during WAIT -> outputs 0, memory zeroed.
REQ-040 LH @0x11 with MEM_MISALIGN_TRAP_EN -> o_misalign=1, o_readData=0; without macro -> data from 0x10, o_misalign=0; LW @(DEPTH*4+0x10) returns word at 0x10.
